// File: rtl/wb_arbiter.sv
// wb_arbiter: merges ALU and load results onto the single register file write port.
// ALU results go directly into a registered write stage; load results are buffered
// in a small circular FIFO that is always drained ahead of the ALU once it fills.
// Optional feature: define WB_STALL_CNT_EN to add the saturating ALU stall counter
// output alu_stall_cnt_o.
module wb_arbiter #(
  parameter int XLEN           = 32,
  parameter int REG_IDX_WIDTH  = 5,
  parameter int LSU_FIFO_DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid_i,
  output logic                     alu_ready_o,
  input  logic [REG_IDX_WIDTH-1:0] alu_rd_idx_i,
  input  logic [XLEN-1:0]          alu_wdata_i,
  input  logic                     lsu_valid_i,
  output logic                     lsu_ready_o,
  input  logic [REG_IDX_WIDTH-1:0] lsu_rd_idx_i,
  input  logic [XLEN-1:0]          lsu_wdata_i,
  output logic                     rd_en_o,
  output logic [REG_IDX_WIDTH-1:0] rd_idx_o,
  output logic [XLEN-1:0]          rd_wdata_o,
  output logic                     lsu_fifo_empty_o
`ifdef WB_STALL_CNT_EN
  ,
  output logic [31:0]              alu_stall_cnt_o
`endif
);

  localparam int PTR_W = (LSU_FIFO_DEPTH > 1) ? $clog2(LSU_FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(LSU_FIFO_DEPTH);

  // Stage p0: load FIFO storage and control state
  logic [REG_IDX_WIDTH-1:0] fifo_idx_p0  [LSU_FIFO_DEPTH];
  logic [XLEN-1:0]          fifo_data_p0 [LSU_FIFO_DEPTH];
  logic [PTR_W-1:0]         rd_ptr_p0;
  logic [PTR_W-1:0]         wr_ptr_p0;
  logic [CNT_W-1:0]         cnt_p0;
  logic                     empty_p0;

  // Stage p1: registered write port
  logic                     rd_vld_p1;
  logic [REG_IDX_WIDTH-1:0] rd_idx_p1;
  logic [XLEN-1:0]          rd_wdata_p1;

  // Arbitration results
  logic                     full;
  logic                     fifo_has_data;
  logic                     push;
  logic                     pop;
  logic                     alu_sel;
  logic                     sel_vld;
  logic [REG_IDX_WIDTH-1:0] sel_idx;
  logic [XLEN-1:0]          sel_wdata;
  logic [CNT_W-1:0]         cnt_next;

  // Saturating increment for the stall counter
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    sat_inc32 = (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Arbitration: a full FIFO drains first, then the ALU, then any buffered load
  always_comb begin
    full          = (cnt_p0 == FULL_CNT);
    fifo_has_data = (cnt_p0 != '0);
    alu_ready_o   = !rst && !full;
    lsu_ready_o   = !rst && !full;
    push          = lsu_valid_i && lsu_ready_o;
    alu_sel       = alu_valid_i && alu_ready_o;
    pop           = full || (!alu_valid_i && fifo_has_data);
    sel_vld       = alu_sel || pop;
    sel_idx       = alu_sel ? alu_rd_idx_i : fifo_idx_p0[rd_ptr_p0];
    sel_wdata     = alu_sel ? alu_wdata_i  : fifo_data_p0[rd_ptr_p0];
    cnt_next      = cnt_p0 + CNT_W'(push) - CNT_W'(pop);
  end

  // FIFO pointers, occupancy and registered empty flag
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_p0 <= '0;
      wr_ptr_p0 <= '0;
      cnt_p0    <= '0;
      empty_p0  <= 1'b1;
    end else begin
      if (push) wr_ptr_p0 <= wr_ptr_p0 + PTR_W'(1);
      if (pop)  rd_ptr_p0 <= rd_ptr_p0 + PTR_W'(1);
      cnt_p0   <= cnt_next;
      empty_p0 <= (cnt_next == '0);
    end
  end

  // FIFO storage: data only, no reset needed
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_idx_p0[wr_ptr_p0]  <= lsu_rd_idx_i;
      fifo_data_p0[wr_ptr_p0] <= lsu_wdata_i;
    end
  end

  // Write stage: x0 writes consume the handshake but never reach the register file
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_vld_p1   <= 1'b0;
      rd_idx_p1   <= '0;
      rd_wdata_p1 <= '0;
    end else begin
      rd_vld_p1 <= sel_vld && (sel_idx != '0);
      if (sel_vld && (sel_idx != '0)) begin
        rd_idx_p1   <= sel_idx;
        rd_wdata_p1 <= sel_wdata;
      end
    end
  end

  assign rd_en_o          = rd_vld_p1;
  assign rd_idx_o         = rd_idx_p1;
  assign rd_wdata_o       = rd_wdata_p1;
  assign lsu_fifo_empty_o = empty_p0;

`ifdef WB_STALL_CNT_EN
  logic [31:0] stall_cnt_p0;

  // Count cycles where the ALU offers a result but the FIFO drain blocks it
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_p0 <= '0;
    end else if (alu_valid_i && !alu_ready_o) begin
      stall_cnt_p0 <= sat_inc32(stall_cnt_p0);
    end
  end

  assign alu_stall_cnt_o = stall_cnt_p0;
`endif

endmodule
